fetch_buffer: RTL and testbench
===============================

Name: fetch_buffer

Overview:
- Instruction prefetch queue between instruction memory and the decode stage.
- Issues sequential word fetches, tracks outstanding requests, and buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to decode through a valid/ready handshake.
- A PC redirect from execute (taken branch or jump) flushes the queue and discards stale in-flight responses.

Parameters:
- DEPTH, 4: FIFO entries; also caps occupancy + in-flight requests. Must be a power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  response data valid; cannot be backpressured.
- imem_resp_data  in  32  returned instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored (forced 0).
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes the instruction.
- out_pc  out  32  PC of the head instruction.
- out_instr  out  32  head instruction word.

Behaviour:
- Reset: fetch_pc = resp_pc = RESET_PC; FIFO empty; inflight = 0; discard_cnt = 0.
- Reset outputs: imem_req_valid = 0; imem_req_addr = RESET_PC; out_valid = 0; out_pc = out_instr = 0.
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && (occupancy + inflight < DEPTH).
  - imem_req_addr = fetch_pc.
  - On request fire (valid && ready): fetch_pc += 4, wrapping modulo 2^32.
- Memory contract:
  - Responses arrive in request order, at least 1 cycle after acceptance.
  - At most one response per cycle.
- Counters:
  - inflight: +1 on request fire, −1 on response; both in one cycle leaves it unchanged.
  - Invariant: discard_cnt ≤ inflight.
- Response handling:
  - If discard_cnt > 0: drop the response and decrement discard_cnt.
  - Otherwise: push {resp_pc, imem_resp_data} and increment resp_pc by 4.
- Overflow is impossible because of the issue credit rule. A push while full is an assertion failure.
- Output:
  - out_valid = FIFO non-empty; out_pc/out_instr = head entry, or zero when empty.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle leave occupancy unchanged; a full FIFO may pop and push in the same cycle.
- Registered path (macro off): a response becomes visible on out_* in the cycle after arrival.
- Redirect (highest priority, single cycle):
  - FIFO cleared; any pop in this cycle is ignored, and the decode handshake in this cycle is void.
  - A response arriving in this cycle is dropped.
  - discard_cnt <= inflight − imem_resp_valid (all remaining outstanding requests are stale).
  - No request is issued in this cycle.
  - fetch_pc <= resp_pc <= {redirect_pc[31:2], 2'b00}.
  - The first post-redirect request can issue on the next cycle.
- Back-to-back redirects: the last one wins, and each recomputes discard_cnt from the current inflight.
- Reset mid-operation: all state returns to reset values. Memory is reset together with this block, so no pre-reset responses arrive.
- FIFO pointers are log2(DEPTH)+1 bits, with the wrap bit used for full/empty.

Optional Feature:
- FETCH_BUF_BYPASS_EN.
- Defined:
  - When the FIFO is empty and a kept (non-discarded) response arrives, it is presented combinationally on out_* in the same cycle.
  - If out_ready is also high, it is consumed without being written to the FIFO.
  - This saves one cycle of fetch-to-decode latency.
- Undefined: every response is registered into the FIFO first (1-cycle minimum latency). The combinational path from imem_resp_* to out_* is absent.

Test Plan:
- Sequential stream, reset then always-ready memory (1-cycle response latency) and out_ready=1 -> out_pc sequence 0x0, 0x4, 0x8, 0xC with matching instr words; no gaps after the pipeline fills.
- Backpressure, out_ready=0 with DEPTH=4 -> exactly 4 requests issue (addresses 0x0–0xC), imem_req_valid then stays 0 and out_pc holds 0x0. After out_ready=1 for one cycle, exactly one new request (0x10) issues.
- Redirect with in-flight requests: memory latency 3, redirect_pc=0x100 while 2 requests are outstanding -> both stale responses dropped, first out_pc=0x100 and next 0x104, no request issued in the redirect cycle.
- Simultaneous redirect and response: response arrives in the redirect cycle with 1 in flight -> discard_cnt=0, that response does not appear, first delivered out_pc equals redirect_pc.
- Wrap and alignment: redirect_pc=0xFFFF_FFFE -> first request addr 0xFFFF_FFFC, next 0x0000_0000.
- Bypass: with FETCH_BUF_BYPASS_EN, empty FIFO and response 0x0000_0013 at cycle N -> out_valid=1 and out_instr=0x13 in cycle N. Without the macro -> visible in cycle N+1.

Source files
------------

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction prefetch queue between instruction memory and decode.
// Sequential word fetches are issued while FIFO occupancy plus in-flight requests
// stay below DEPTH, so the FIFO can never overflow. A redirect flushes the queue
// and marks every outstanding request as stale so its response gets dropped.
// Optional macro FETCH_BUF_BYPASS_EN: a kept response that arrives while the FIFO
// is empty is shown on out_* in the same cycle. If decode takes it in that cycle,
// it never enters the FIFO.
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   occupancy;
  logic [AW:0]   inflight;
  logic [AW:0]   discard_cnt;
  logic [AW+1:0] credit_sum;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic        fifo_empty;
  logic        fifo_full;
  logic        fifo_push;
  logic        fifo_pop;
  logic        req_fire;
  logic        resp_keep;
  logic [31:0] redirect_aligned;
  logic [AW:0] resp_dec;

  assign occupancy  = wr_ptr - rd_ptr;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign credit_sum = {1'b0, occupancy} + {1'b0, inflight};

  assign imem_req_valid = !reset && !redirect_valid && (credit_sum < DEPTH_W);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses during a redirect or while stale ones are pending are never kept.
  assign resp_keep        = imem_resp_valid && (discard_cnt == '0) && !redirect_valid;
  assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign resp_dec         = (AW+1)'(imem_resp_valid);
  assign fifo_pop         = !fifo_empty && out_ready && !redirect_valid;

`ifdef FETCH_BUF_BYPASS_EN
  logic bypass_hit;
  logic bypass_take;

  assign bypass_hit  = fifo_empty && resp_keep;
  assign bypass_take = bypass_hit && out_ready;
  assign fifo_push   = resp_keep && !bypass_take;

  // Head of FIFO, or the arriving response when the FIFO is empty.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_pc    = pc_mem[rd_ptr[AW-1:0]];
      out_instr = instr_mem[rd_ptr[AW-1:0]];
    end else if (bypass_hit) begin
      out_valid = 1'b1;
      out_pc    = resp_pc;
      out_instr = imem_resp_data;
    end
  end
`else
  assign fifo_push = resp_keep;

  // Head of FIFO; zeros when empty.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = '0;
    out_instr = '0;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_pc    = pc_mem[rd_ptr[AW-1:0]];
      out_instr = instr_mem[rd_ptr[AW-1:0]];
    end
  end
`endif

  // FIFO storage; contents are qualified by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      pc_mem[wr_ptr[AW-1:0]]    <= resp_pc;
      instr_mem[wr_ptr[AW-1:0]] <= imem_resp_data;
    end
  end

  // FIFO pointers; a redirect empties the queue and voids any pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Fetch and response PCs; a redirect realigns both to the new target.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_aligned;
      resp_pc  <= redirect_aligned;
    end else begin
      if (req_fire)  fetch_pc <= fetch_pc + 32'd4;
      if (resp_keep) resp_pc  <= resp_pc + 32'd4;
    end
  end

  // Outstanding request count and number of stale responses still to drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight    <= '0;
      discard_cnt <= '0;
    end else if (redirect_valid) begin
      inflight    <= inflight - resp_dec;
      discard_cnt <= inflight - resp_dec;
    end else begin
      case ({req_fire, imem_resp_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      if (imem_resp_valid && (discard_cnt != '0)) discard_cnt <= discard_cnt - 1'b1;
    end
  end

  // The issue credit rule must make a push into a full, non-draining FIFO impossible.
  always_ff @(posedge clk) begin
    if (!reset) assert (!(fifo_push && fifo_full && !fifo_pop));
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed tests with a scoreboard queue checked by a separate
// monitor whenever decode takes an instruction. The memory model returns
// addr + 0x13 after a programmable latency.
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instr       (out_instr)
  );

  always #5 clk = ~clk;

`ifdef FETCH_BUF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  req_t        pend[$];
  logic [31:0] req_log[$];
  logic [63:0] sb_q[$];
  int          deliv_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Memory model: in-order responses, one per cycle, 'lat' cycles after acceptance.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      imem_resp_valid = 1'b0;
      pend.delete();
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = pend[0].addr + 32'h13;
      void'(pend.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
    end
  end

  // Request capture: fires are observed mid-cycle, ahead of the accepting edge.
  always @(negedge clk) begin
    if (!reset && imem_req_valid && imem_req_ready) begin
      req_log.push_back(imem_req_addr);
      pend.push_back('{addr: imem_req_addr, due: cyc + lat});
    end
  end

  // Monitor: every decode handshake is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && !redirect_valid && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_out: got pc=%h instr=%h want no output", out_pc, out_instr);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("out_pc", out_pc, e[63:32]);
        check("out_instr", out_instr, e[31:0]);
        deliv_cyc.push_back(cyc);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input logic [31:0] pc, input logic [31:0] instr);
    sb_q.push_back({pc, instr});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    step(1);
    @(negedge clk);
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_out_instr", out_instr, 32'h0);
    @(posedge clk);
    #1;
    sb_q.delete();
    req_log.delete();
    deliv_cyc.delete();
    reset = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (sb_q.size() > 0 && n < bound) begin
      step(1);
      n++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d entries left want 0", sb_q.size());
    end
    out_ready = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    @(negedge clk);
    check("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Sequential stream with single-cycle memory and always-ready decode.
    do_reset();
    lat = 1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) expect_out(32'(i * 4), 32'(i * 4 + 32'h13));
    drain(40);
    check("stream_count", 32'(deliv_cyc.size()), 32'd8);
    if (deliv_cyc.size() == 8) check("stream_gapless", 32'(deliv_cyc[7] - deliv_cyc[0]), 32'd7);

    // Backpressure: credit stops issue at DEPTH, one pop frees one request.
    do_reset();
    lat = 1;
    step(12);
    check("bp_req_count", 32'(req_log.size()), 32'd4);
    if (req_log.size() >= 4) begin
      check("bp_addr0", req_log[0], 32'h0);
      check("bp_addr1", req_log[1], 32'h4);
      check("bp_addr2", req_log[2], 32'h8);
      check("bp_addr3", req_log[3], 32'hC);
    end
    @(negedge clk);
    check("bp_req_stalled", {31'd0, imem_req_valid}, 32'd0);
    check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    check("bp_out_pc_hold", out_pc, 32'h0);
    expect_out(32'h0, 32'h13);
    expect_out(32'h4, 32'h17);
    expect_out(32'h8, 32'h1B);
    expect_out(32'hC, 32'h1F);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
    step(6);
    check("bp_req_count_after", 32'(req_log.size()), 32'd5);
    if (req_log.size() >= 5) check("bp_addr4", req_log[4], 32'h10);
    check("bp_one_pop", 32'(sb_q.size()), 32'd3);
    @(negedge clk);
    check("bp_req_stalled2", {31'd0, imem_req_valid}, 32'd0);

    // Redirect with two requests outstanding at latency 3.
    do_reset();
    lat = 3;
    out_ready = 1'b1;
    step(2);
    expect_out(32'h100, 32'h113);
    expect_out(32'h104, 32'h117);
    expect_out(32'h108, 32'h11B);
    expect_out(32'h10C, 32'h11F);
    pulse_redirect(32'h100);
    drain(60);
    check("redir_req_count", {31'd0, req_log.size() >= 3}, 32'd1);
    if (req_log.size() >= 3) begin
      check("redir_req0", req_log[0], 32'h0);
      check("redir_req1", req_log[1], 32'h4);
      check("redir_req2", req_log[2], 32'h100);
    end

    // Redirect in the same cycle as the only outstanding response.
    do_reset();
    lat = 1;
    out_ready = 1'b1;
    step(1);
    expect_out(32'h200, 32'h213);
    expect_out(32'h204, 32'h217);
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    check("sim_no_req", {31'd0, imem_req_valid}, 32'd0);
    check("sim_resp_hidden", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    drain(40);

    // Unaligned redirect near the top of the address space wraps to zero.
    do_reset();
    lat = 1;
    out_ready = 1'b1;
    expect_out(32'hFFFF_FFFC, 32'h0000_000F);
    expect_out(32'h0000_0000, 32'h0000_0013);
    pulse_redirect(32'hFFFF_FFFE);
    drain(40);
    check("wrap_req_count", {31'd0, req_log.size() >= 2}, 32'd1);
    if (req_log.size() >= 2) begin
      check("wrap_req0", req_log[0], 32'hFFFF_FFFC);
      check("wrap_req1", req_log[1], 32'h0000_0000);
    end

    // Fetch-to-decode latency: same cycle with bypass, one cycle later without.
    do_reset();
    lat = 1;
    out_ready = 1'b0;
    step(1);
    @(negedge clk);
    check("lat_resp_cycle_valid", {31'd0, out_valid}, {31'd0, BYP});
    check("lat_resp_cycle_instr", out_instr, BYP ? 32'h13 : 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("lat_next_valid", {31'd0, out_valid}, 32'd1);
    check("lat_next_pc", out_pc, 32'h0);
    check("lat_next_instr", out_instr, 32'h13);

    // Reset while the FIFO holds data.
    do_reset();
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
